// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared LSU definitions: MemOp encodings, FSM states
// and the store byte-lane mask helper.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] op,
    input logic [1:0] off
  );
    case (op[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Load data extraction: picks byte/half from the bus word
// and sign- or zero-extends it per MemOp.
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] res
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = 8'(rdata >> {off, 3'b000});
    h   = off[1] ? rdata[31:16] : rdata[15:0];
    res = rdata;
    case (op)
      MOP_B:   res = {{24{b[7]}}, b};
      MOP_H:   res = {{16{h[15]}}, h};
      MOP_BU:  res = {24'b0, b};
      MOP_HU:  res = {16'b0, h};
      default: res = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: one outstanding valid/ready
// data-memory transaction with timeout and error reporting.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [2:0]  in_op,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  lsu_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0] addr_q, wdata_q, res_q;
  logic [3:0]  wmask_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        wen_q, err_q;

  logic        accept, none, illegal;
  logic        legal_op, misal;
  logic        rsp_hit, tmo;
  logic [31:0] st_data, ld_res;

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_DONE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign out_rdata     = res_q;
  assign out_err       = err_q;

  assign accept = in_valid & in_ready;

  always_comb begin
    legal_op = 1'b0;
    case (in_op)
      MOP_B, MOP_H, MOP_W: legal_op = 1'b1;
      MOP_BU, MOP_HU:      legal_op = ~in_write;
      default:             legal_op = 1'b0;
    endcase
    misal = ((in_op[1:0] == 2'b01) & in_addr[0])
          | ((in_op[1:0] == 2'b10) & (|in_addr[1:0]));
    none    = ~in_read & ~in_write;
    illegal = (in_read & in_write) | ~legal_op | misal;
  end

  // Replicate store data across all lanes; the mask selects.
  always_comb begin
    case (in_op[1:0])
      2'b00:   st_data = {4{in_wdata[7:0]}};
      2'b01:   st_data = {2{in_wdata[15:0]}};
      default: st_data = in_wdata;
    endcase
  end

  assign rsp_hit = (state_q == S_WAIT) & mem_rsp_valid;
  assign tmo     = (state_q == S_WAIT) & ~mem_rsp_valid
                 & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (none | illegal) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_hit | tmo) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      wmask_q <= '0;
      op_q    <= '0;
      off_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= {in_addr[31:2], 2'b00};
        off_q   <= in_addr[1:0];
        op_q    <= in_op;
        wen_q   <= in_write;
        wmask_q <= in_write ?
                   lane_mask(in_op, in_addr[1:0]) : 4'b0;
        wdata_q <= in_write ? st_data : '0;
        res_q   <= '0;
        err_q   <= ~none & illegal;
      end
      if ((state_q == S_REQ) & mem_req_ready)
        cnt_q <= '0;
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (rsp_hit) begin
        err_q <= mem_rsp_err;
        res_q <= (mem_rsp_err | wen_q) ? '0 : ld_res;
      end else if (tmo) begin
        err_q <= 1'b1;
        res_q <= '0;
      end
    end
  end

  lsu_load_align u_align (
    .rdata (mem_rdata),
    .off   (off_q),
    .op    (op_q),
    .res   (ld_res)
  );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed table, reset corner case,
// randomized ops checked against a behavioural model.
module tb_lsu_mem_ctrl;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic        in_read, in_write;
  logic [2:0]  in_op;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  int total = 0;
  int bad   = 0;

  lsu_mem_ctrl #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_read       (in_read),
    .in_write      (in_write),
    .in_op         (in_op),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    bit          rd, wr, rsp_err;
    logic [2:0]  op;
    int          req_stall, rsp_delay, out_stall;
    bit          x_req, x_err;
    logic [3:0]  x_wmask;
    logic [31:0] x_wdata, x_rdata;
  } vec_t;

  typedef struct {
    bit          req, wen, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask;
    int          lat;
  } exp_t;

  typedef struct {
    bit          saw_req, req_unstable, hang;
    bit          out_unstable, inready_bad;
    bit          wen, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask;
    int          lat;
  } obs_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: size/offset arithmetic on the op rules.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int sz, off;
    bit sgn, legal, got;
    logic [31:0] val;
    e = '{default: 0};
    off = int'(v.addr % 4);
    sz = (v.op[1:0] == 2'b00) ? 1 :
         (v.op[1:0] == 2'b01) ? 2 :
         (v.op[1:0] == 2'b10) ? 4 : 0;
    sgn = (v.op[2] == 1'b0);
    legal = (sz != 0) && !(v.op[2] && sz == 4)
         && !(v.op[2] && v.wr) && !(v.rd && v.wr)
         && (off % sz == 0);
    e.lat = 1;
    if (!v.rd && !v.wr) return e;
    if (!legal) begin
      e.err = 1;
      return e;
    end
    e.req  = 1;
    e.addr = v.addr - 32'(off);
    e.wen  = v.wr;
    if (v.wr) begin
      e.wmask = 4'(((1 << sz) - 1) << off);
      e.wdata = (sz == 1) ? (v.wdata & 32'hFF) * 32'h01010101 :
                (sz == 2) ? (v.wdata & 32'hFFFF) * 32'h00010001 :
                v.wdata;
    end
    got = (v.rsp_delay >= 0) && (v.rsp_delay < TMO);
    e.lat = got ? v.req_stall + 3 + v.rsp_delay
                : v.req_stall + 2 + TMO;
    e.err = !got || v.rsp_err;
    if (e.err || v.wr) return e;
    val = (v.rdata >> (8 * off));
    if (sz == 1) val = val & 32'hFF;
    if (sz == 2) val = val & 32'hFFFF;
    if (sgn && sz == 1 && val >= 32'h80) val = val - 32'h100;
    if (sgn && sz == 2 && val >= 32'h8000) val = val - 32'h10000;
    e.rdata = val;
    return e;
  endfunction

  task automatic run_op(input vec_t v, output obs_t o);
    int stall, widx, ostall;
    bit in_wait, in_done, fin;
    o = '{default: 0};
    stall = 0; widx = 0; ostall = 0;
    in_wait = 0; in_done = 0; fin = 0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1; in_addr = v.addr; in_wdata = v.wdata;
    in_read = v.rd; in_write = v.wr; in_op = v.op;
    @(negedge clk);
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom;
    in_read = 1'($urandom); in_write = 1'($urandom);
    in_op = 3'($urandom);
    o.hang = 1;
    for (int c = 1; c < 80; c++) begin
      mem_rsp_valid = 0; mem_req_ready = 0; out_ready = 0;
      mem_rdata = $urandom; mem_rsp_err = 1'($urandom);
      if (fin) begin
        o.hang = 0;
        break;
      end
      if (in_wait) begin
        if (widx == v.rsp_delay) begin
          mem_rsp_valid = 1;
          mem_rdata = v.rdata;
          mem_rsp_err = v.rsp_err;
        end
        widx++;
      end
      if (mem_req_valid) begin
        mem_rsp_valid = 1'($urandom);
        if (!o.saw_req) begin
          o.saw_req = 1; o.addr = mem_addr; o.wen = mem_wen;
          o.wdata = mem_wdata; o.wmask = mem_wmask;
        end else if (o.addr !== mem_addr || o.wen !== mem_wen
            || o.wdata !== mem_wdata || o.wmask !== mem_wmask)
          o.req_unstable = 1;
        if (stall < v.req_stall) stall++;
        else begin
          mem_req_ready = 1;
          in_wait = 1;
          widx = 0;
        end
      end
      if (out_valid) begin
        if (!in_done) begin
          in_done = 1; o.lat = c;
          o.rdata = out_rdata; o.err = out_err;
        end else if (o.rdata !== out_rdata || o.err !== out_err)
          o.out_unstable = 1;
        if (in_ready) o.inready_bad = 1;
        if (ostall < v.out_stall) ostall++;
        else begin
          out_ready = 1;
          fin = 1;
        end
      end
      @(negedge clk);
    end
    mem_rsp_valid = 0; mem_req_ready = 0; out_ready = 0;
  endtask

  task automatic check_op(input vec_t v, input exp_t e,
                          input obs_t o);
    chk("hang", 32'(o.hang), 32'd0);
    chk("req_seen", 32'(o.saw_req), 32'(e.req));
    if (e.req) begin
      chk("mem_addr", o.addr, e.addr);
      chk("mem_wen", 32'(o.wen), 32'(e.wen));
      chk("mem_wmask", 32'(o.wmask), 32'(e.wmask));
      if (v.wr) chk("mem_wdata", o.wdata, e.wdata);
      chk("req_stable", 32'(o.req_unstable), 32'd0);
    end
    chk("out_rdata", o.rdata, e.rdata);
    chk("out_err", 32'(o.err), 32'(e.err));
    chk("latency", 32'(o.lat), 32'(e.lat));
    chk("out_stable", 32'(o.out_unstable), 32'd0);
    chk("in_ready_busy", 32'(o.inready_bad), 32'd0);
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] wdata,
    input bit rd, input bit wr, input logic [2:0] op,
    input int rs, input int rd_dly, input int os,
    input logic [31:0] rdata, input bit rerr,
    input bit xr, input logic [3:0] xm,
    input logic [31:0] xw, input logic [31:0] xd, input bit xe);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr;
    v.op = op; v.req_stall = rs; v.rsp_delay = rd_dly;
    v.out_stall = os; v.rdata = rdata; v.rsp_err = rerr;
    v.x_req = xr; v.x_wmask = xm; v.x_wdata = xw;
    v.x_rdata = xd; v.x_err = xe;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    vec_t v;
    exp_t e;
    obs_t o;
    rst = 1; in_valid = 0; in_addr = 0; in_wdata = 0;
    in_read = 0; in_write = 0; in_op = 0;
    mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rdata = 0; mem_rsp_err = 0; out_ready = 0;

    tbl[0]  = mk(32'h1003, 0, 1, 0, 3'b000, 0, 0, 0,
                 32'h80FF1234, 0, 1, 4'h0, 0, 32'hFFFFFF80, 0);
    tbl[1]  = mk(32'h2002, 32'h0000BEEF, 0, 1, 3'b001, 3, 1, 0,
                 0, 0, 1, 4'hC, 32'hBEEFBEEF, 0, 0);
    tbl[2]  = mk(32'h3001, 0, 1, 0, 3'b010, 0, 0, 0,
                 0, 0, 0, 4'h0, 0, 0, 1);
    tbl[3]  = mk(32'h4002, 0, 1, 0, 3'b101, 0, 0, 5,
                 32'hA5A50000, 0, 1, 4'h0, 0, 32'h0000A5A5, 0);
    tbl[4]  = mk(32'h5000, 0, 1, 0, 3'b010, 0, 4, 2,
                 32'h11112222, 0, 1, 4'h0, 0, 0, 1);
    tbl[5]  = mk(32'h5123, 32'h77, 0, 0, 3'b111, 0, 0, 1,
                 0, 0, 0, 4'h0, 0, 0, 0);
    tbl[6]  = mk(32'h5200, 0, 1, 1, 3'b010, 0, 0, 0,
                 0, 0, 0, 4'h0, 0, 0, 1);
    tbl[7]  = mk(32'h6001, 32'h123456AB, 0, 1, 3'b000, 1, 0, 0,
                 0, 0, 1, 4'h2, 32'hABABABAB, 0, 0);
    tbl[8]  = mk(32'h7000, 0, 1, 0, 3'b001, 0, 2, 0,
                 32'h12348001, 0, 1, 4'h0, 0, 32'hFFFF8001, 0);
    tbl[9]  = mk(32'h8000, 0, 1, 0, 3'b010, 0, 1, 0,
                 32'hDEADBEEF, 1, 1, 4'h0, 0, 0, 1);
    tbl[10] = mk(32'h8100, 32'h55, 0, 1, 3'b100, 0, 0, 0,
                 0, 0, 0, 4'h0, 0, 0, 1);
    tbl[11] = mk(32'h9002, 0, 1, 0, 3'b100, 0, 0, 0,
                 32'h00C30000, 0, 1, 4'h0, 0, 32'h000000C3, 0);
    tbl[12] = mk(32'hA000, 0, 1, 0, 3'b010, 0, 3, 0,
                 32'h12345678, 0, 1, 4'h0, 0, 32'h12345678, 0);
    tbl[13] = mk(32'hA100, 0, 1, 0, 3'b011, 0, 0, 0,
                 0, 0, 0, 4'h0, 0, 0, 1);
    tbl[14] = mk(32'hB000, 32'hCAFEF00D, 0, 1, 3'b010, 2, 2, 1,
                 0, 0, 1, 4'hF, 32'hCAFEF00D, 0, 0);

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      v = tbl[i];
      e = model(v);
      e.req = v.x_req; e.wmask = v.x_wmask;
      e.wdata = v.x_wdata; e.rdata = v.x_rdata; e.err = v.x_err;
      run_op(v, o);
      check_op(v, e, o);
    end

    // Asynchronous reset while a load waits for its response.
    in_valid = 1; in_addr = 32'hC004; in_read = 1;
    in_write = 0; in_op = 3'b010;
    @(negedge clk);
    in_valid = 0;
    chk("rstw_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 rst = 1;
    #1;
    chk("rstw_in_ready", 32'(in_ready), 32'd1);
    chk("rstw_req_valid0", 32'(mem_req_valid), 32'd0);
    chk("rstw_out_valid", 32'(out_valid), 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'd0);
    chk("rstw_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst = 0;
    v = mk(32'hC008, 0, 1, 0, 3'b010, 0, 0, 0,
           32'h0BADF00D, 0, 0, 0, 0, 0, 0);
    run_op(v, o);
    check_op(v, model(v), o);

    for (int n = 0; n < 200; n++) begin
      v = mk($urandom, $urandom, 0, 0, 3'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 5),
             $urandom_range(0, 3), $urandom,
             ($urandom_range(0, 7) == 0), 0, 0, 0, 0, 0);
      case ($urandom_range(0, 9))
        0:          begin v.rd = 0; v.wr = 0; end
        1:          begin v.rd = 1; v.wr = 1; end
        2, 3, 4, 5: begin v.rd = 1; v.wr = 0; end
        default:    begin v.rd = 0; v.wr = 1; end
      endcase
      if ($urandom_range(0, 2) != 0) v.addr[1:0] = 2'b00;
      run_op(v, o);
      check_op(v, model(v), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
